// File: rtl/i2c_pkg.sv
// ----------------------------------------------------------------------------
// i2c_pkg
// Shared types and constants for the I2C target (responder).
//   I2C_ADDR_WIDTH / I2C_DATA_WIDTH : address and data byte widths
//   i2c_slave_state_t               : protocol FSM state encoding
//   i2c_bus_event_t                 : decoded bus events (one-cycle flags)
// ----------------------------------------------------------------------------
package i2c_pkg;

  localparam int I2C_ADDR_WIDTH = 7;
  localparam int I2C_DATA_WIDTH = 8;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_DATA,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_DATA,
    ST_RD_ACK,
    ST_SKIP
  } i2c_slave_state_t;

  typedef struct packed {
    logic start;     // SDA fell while SCL high
    logic stop;      // SDA rose while SCL high
    logic scl_rise;
    logic scl_fall;
  } i2c_bus_event_t;

endpackage

// File: rtl/i2c_slave_responder_if.sv
// ----------------------------------------------------------------------------
// i2c_slave_responder_if
// Bus pins plus user-side write/read handshake of the I2C target.
//   scl_i/sda_i     : bus levels seen by the target (asynchronous)
//   scl_o/sda_o     : open-drain drives, 1 = release, 0 = pull low
//   start_o/stop_o  : one-cycle bus condition pulses; busy_o START..STOP
//   wr_data_o/wr_valid_o          : received write byte + strobe
//   rd_req_o/rd_data_i/rd_valid_i : read byte request/handshake
//   rd_underrun_o   : pulse when 0xFF was substituted for a late read byte
// Modports: slave (the target), master (the bus/user side driving it).
// ----------------------------------------------------------------------------
interface i2c_slave_responder_if;
  import i2c_pkg::*;

  logic                      scl_i;
  logic                      sda_i;
  logic                      scl_o;
  logic                      sda_o;
  logic                      start_o;
  logic                      stop_o;
  logic                      busy_o;
  logic [I2C_DATA_WIDTH-1:0] wr_data_o;
  logic                      wr_valid_o;
  logic                      rd_req_o;
  logic [I2C_DATA_WIDTH-1:0] rd_data_i;
  logic                      rd_valid_i;
  logic                      rd_underrun_o;

  modport slave (
    input  scl_i, sda_i, rd_data_i, rd_valid_i,
    output scl_o, sda_o, start_o, stop_o, busy_o,
           wr_data_o, wr_valid_o, rd_req_o, rd_underrun_o
  );

  modport master (
    output scl_i, sda_i, rd_data_i, rd_valid_i,
    input  scl_o, sda_o, start_o, stop_o, busy_o,
           wr_data_o, wr_valid_o, rd_req_o, rd_underrun_o
  );

endinterface

// File: rtl/i2c_bus_sync.sv
// ----------------------------------------------------------------------------
// i2c_bus_sync
// Brings the asynchronous SCL/SDA levels into the clk_i domain and decodes
// bus events from the synchronized samples.
//   clk_i, rst_ni : system clock, synchronous active-low reset
//   i_scl, i_sda  : raw bus levels
//   o_evt         : START / STOP / SCL rise / SCL fall, valid for one cycle
//   o_sda         : synchronized SDA, aligned with o_evt (data bit sample)
// Latency: a pin change shows up in o_evt two cycles later and is acted on
// by the FSM register on the third.
// ----------------------------------------------------------------------------
module i2c_bus_sync
  import i2c_pkg::*;
(
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           i_scl,
  input  logic           i_sda,
  output i2c_bus_event_t o_evt,
  output logic           o_sda
);

  logic r_scl_meta, r_scl_sync, r_scl_prev;
  logic r_sda_meta, r_sda_sync, r_sda_prev;

  // NOTE: two flops before any logic looks at a pin; the first may go
  // metastable and must never fan out.
  always_ff @(posedge clk_i) begin
    // NOTE: reset to the idle bus level (high) so leaving reset on an idle
    // bus produces no phantom edge or START.
    if (!rst_ni) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // value of its source, forming a real shift chain.
      r_scl_meta <= i_scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= i_sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
    end
  end

  // START/STOP require SCL high in both samples, so they never coincide
  // with an SCL edge flag.
  always_comb begin
    o_evt.start    = r_scl_sync &  r_scl_prev &  r_sda_prev & ~r_sda_sync;
    o_evt.stop     = r_scl_sync &  r_scl_prev & ~r_sda_prev &  r_sda_sync;
    o_evt.scl_rise = r_scl_sync & ~r_scl_prev;
    o_evt.scl_fall = ~r_scl_sync & r_scl_prev;
  end

  assign o_sda = r_sda_sync;

endmodule

// File: rtl/i2c_slave_responder.sv
// ----------------------------------------------------------------------------
// i2c_slave_responder
// I2C target answering a single 7-bit address. Write bytes are presented on
// wr_data_o with a wr_valid_o strobe; read bytes are fetched through the
// rd_req_o / rd_valid_i handshake, one request per byte.
//   clk_i  : system clock (must be >= 16x SCL)
//   rst_ni : synchronous active-low reset
//   bus    : i2c_slave_responder_if.slave (bus pins + user handshake)
// Parameter SLAVE_ADDR: 7-bit target address (0x44 write / 0x45 read).
// Build option I2C_SLAVE_STRETCH_EN: when defined, a read byte that is not
// ready holds SCL low until it is; otherwise 0xFF is sent, rd_underrun_o
// pulses and scl_o is constantly released.
// ----------------------------------------------------------------------------
module i2c_slave_responder
  import i2c_pkg::*;
#(
  parameter logic [I2C_ADDR_WIDTH-1:0] SLAVE_ADDR = 7'h22
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  i2c_slave_responder_if.slave  bus
);

`ifdef I2C_SLAVE_STRETCH_EN
  localparam bit STRETCH_EN = 1'b1;
`else
  localparam bit STRETCH_EN = 1'b0;
`endif

  i2c_bus_event_t            w_evt;
  logic                      w_sda;
  logic [I2C_DATA_WIDTH-1:0] w_byte;

  i2c_slave_state_t          r_state,    w_nxt_state;
  logic [2:0]                r_cnt,      w_nxt_cnt;
  logic [I2C_DATA_WIDTH-1:0] r_shift,    w_nxt_shift;
  logic                      r_rw,       w_nxt_rw;
  logic                      r_mack,     w_nxt_mack;
  logic                      r_sda_o,    w_nxt_sda_o;
  logic                      r_scl_o,    w_nxt_scl_o;
  logic                      r_rd_req,   w_nxt_rd_req;
  logic [I2C_DATA_WIDTH-1:0] r_wr_data,  w_nxt_wr_data;
  logic                      r_wr_valid, w_nxt_wr_valid;
  logic                      r_start,    w_nxt_start;
  logic                      r_stop,     w_nxt_stop;
  logic                      r_underrun, w_nxt_underrun;

  i2c_bus_sync u_sync (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_scl  (bus.scl_i),
    .i_sda  (bus.sda_i),
    .o_evt  (w_evt),
    .o_sda  (w_sda)
  );

  // Byte as it stands after shifting in the bit sampled on this SCL rise.
  assign w_byte = {r_shift[I2C_DATA_WIDTH-2:0], w_sda};

  always_comb begin
    // NOTE: defaults first; every path then leaves each signal assigned,
    // so no latch is inferred.
    w_nxt_state    = r_state;
    w_nxt_cnt      = r_cnt;
    w_nxt_shift    = r_shift;
    w_nxt_rw       = r_rw;
    w_nxt_mack     = r_mack;
    w_nxt_sda_o    = r_sda_o;
    w_nxt_scl_o    = r_scl_o;
    w_nxt_rd_req   = r_rd_req;
    w_nxt_wr_data  = r_wr_data;
    w_nxt_wr_valid = 1'b0;
    w_nxt_start    = 1'b0;
    w_nxt_stop     = 1'b0;
    w_nxt_underrun = 1'b0;

    if (w_evt.start) begin
      // START or repeated START restarts address reception from any state.
      w_nxt_state  = ST_ADDR;
      w_nxt_cnt    = '0;
      w_nxt_sda_o  = 1'b1;
      w_nxt_scl_o  = 1'b1;
      w_nxt_rd_req = 1'b0;
      w_nxt_start  = 1'b1;
    end else if (w_evt.stop) begin
      w_nxt_stop = 1'b1;
      if (r_state != ST_IDLE) begin
        w_nxt_state  = ST_IDLE;
        w_nxt_cnt    = '0;
        w_nxt_sda_o  = 1'b1;
        w_nxt_scl_o  = 1'b1;
        w_nxt_rd_req = 1'b0;
      end
    end else begin
      unique case (r_state)
        ST_ADDR: begin
          if (w_evt.scl_rise) begin
            w_nxt_shift = w_byte;
            if (r_cnt == 3'd7) begin
              w_nxt_cnt   = '0;
              w_nxt_rw    = w_byte[0];
              w_nxt_state = (w_byte[7:1] == SLAVE_ADDR) ? ST_ADDR_ACK : ST_SKIP;
            end else begin
              w_nxt_cnt = r_cnt + 3'd1;
            end
          end
        end

        // ACK states: the first SCL fall (end of bit 8) pulls SDA low, the
        // second (end of the ACK clock) releases it and moves on.
        ST_ADDR_ACK: begin
          if (w_evt.scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_nxt_sda_o = 1'b0;
              w_nxt_cnt   = 3'd1;
            end else begin
              w_nxt_sda_o = 1'b1;
              w_nxt_cnt   = '0;
              if (r_rw) begin
                w_nxt_state  = ST_RD_LOAD;
                w_nxt_rd_req = 1'b1;
                if (STRETCH_EN) w_nxt_scl_o = 1'b0;
              end else begin
                w_nxt_state = ST_WR_DATA;
              end
            end
          end
        end

        ST_WR_DATA: begin
          if (w_evt.scl_rise) begin
            w_nxt_shift = w_byte;
            if (r_cnt == 3'd7) begin
              w_nxt_cnt      = '0;
              w_nxt_wr_data  = w_byte;
              w_nxt_wr_valid = 1'b1;
              w_nxt_state    = ST_WR_ACK;
            end else begin
              w_nxt_cnt = r_cnt + 3'd1;
            end
          end
        end

        ST_WR_ACK: begin
          if (w_evt.scl_fall) begin
            if (r_cnt == 3'd0) begin
              w_nxt_sda_o = 1'b0;
              w_nxt_cnt   = 3'd1;
            end else begin
              w_nxt_sda_o = 1'b1;
              w_nxt_cnt   = '0;
              w_nxt_state = ST_WR_DATA;
            end
          end
        end

        // SCL is low here; bit 7 goes out as soon as the byte is known.
        ST_RD_LOAD: begin
          if (r_rd_req && bus.rd_valid_i) begin
            w_nxt_shift  = bus.rd_data_i;
            w_nxt_sda_o  = bus.rd_data_i[7];
            w_nxt_rd_req = 1'b0;
            w_nxt_scl_o  = 1'b1;
            w_nxt_cnt    = '0;
            w_nxt_state  = ST_RD_DATA;
          end else if (!STRETCH_EN) begin
            // Deadline missed: send all-ones, which leaves SDA released.
            w_nxt_shift    = '1;
            w_nxt_sda_o    = 1'b1;
            w_nxt_rd_req   = 1'b0;
            w_nxt_underrun = 1'b1;
            w_nxt_cnt      = '0;
            w_nxt_state    = ST_RD_DATA;
          end
        end

        // Each SCL fall ends one bit; the eighth releases SDA for the
        // master's ACK.
        ST_RD_DATA: begin
          if (w_evt.scl_fall) begin
            if (r_cnt == 3'd7) begin
              w_nxt_sda_o = 1'b1;
              w_nxt_cnt   = '0;
              w_nxt_state = ST_RD_ACK;
            end else begin
              w_nxt_sda_o = r_shift[6];
              w_nxt_shift = {r_shift[I2C_DATA_WIDTH-2:0], 1'b0};
              w_nxt_cnt   = r_cnt + 3'd1;
            end
          end
        end

        ST_RD_ACK: begin
          if (w_evt.scl_rise) begin
            w_nxt_mack = ~w_sda;
          end else if (w_evt.scl_fall) begin
            if (r_mack) begin
              w_nxt_state  = ST_RD_LOAD;
              w_nxt_rd_req = 1'b1;
              if (STRETCH_EN) w_nxt_scl_o = 1'b0;
            end else begin
              w_nxt_state = ST_SKIP;
            end
          end
        end

        ST_IDLE, ST_SKIP: ;

        default: w_nxt_state = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
      r_sda_o    <= 1'b1;
      r_scl_o    <= 1'b1;
      r_rd_req   <= 1'b0;
      r_wr_data  <= '0;
      r_wr_valid <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_state    <= w_nxt_state;
      r_cnt      <= w_nxt_cnt;
      r_shift    <= w_nxt_shift;
      r_rw       <= w_nxt_rw;
      r_mack     <= w_nxt_mack;
      r_sda_o    <= w_nxt_sda_o;
      r_scl_o    <= w_nxt_scl_o;
      r_rd_req   <= w_nxt_rd_req;
      r_wr_data  <= w_nxt_wr_data;
      r_wr_valid <= w_nxt_wr_valid;
      r_start    <= w_nxt_start;
      r_stop     <= w_nxt_stop;
      r_underrun <= w_nxt_underrun;
    end
  end

  assign bus.sda_o         = r_sda_o;
  assign bus.scl_o         = STRETCH_EN ? r_scl_o : 1'b1;
  assign bus.busy_o        = (r_state != ST_IDLE);
  assign bus.start_o       = r_start;
  assign bus.stop_o        = r_stop;
  assign bus.wr_data_o     = r_wr_data;
  assign bus.wr_valid_o    = r_wr_valid;
  assign bus.rd_req_o      = r_rd_req;
  assign bus.rd_underrun_o = r_underrun;

endmodule
